// File: rtl/harness_word_serializer_pkg.sv
// Shared definitions for the single-pin harness word serializer.
//   state_t              : FSM state encoding (IDLE / SHIFT / GAP)
//   DEFAULT_CMD_WIDTH    : width of the point-multiplier command word
//   DEFAULT_RESULT_WIDTH : width of the matching result word
//   clog2()              : ceiling log2, usable in constant expressions
package harness_word_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_CMD_WIDTH    = 286;
    localparam int DEFAULT_RESULT_WIDTH = 567;

    // clog2(0) and clog2(1) both return 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << result) < 64'(value)) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/harness_word_serializer_if.sv
// Handshake and serial-line bundle between a word source and the serializer.
//   clear         : synchronous abort from the source
//   word_in       : parallel word, WORD_WIDTH bits
//   word_in_valid : word_in carries a word
//   word_in_ready : serializer accepts a word this cycle
//   bit_out       : serial data
//   bit_out_valid : bit_out carries a word bit
//   busy          : serializer not idle
//   done          : pulse with the last bit of a word
interface harness_word_serializer_if
    import harness_word_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_CMD_WIDTH
) ();

    logic                  clear;
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_in_valid;
    logic                  word_in_ready;
    logic                  bit_out;
    logic                  bit_out_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output clear, word_in, word_in_valid,
        input  word_in_ready, bit_out, bit_out_valid, busy, done
    );

    modport slave (
        input  clear, word_in, word_in_valid,
        output word_in_ready, bit_out, bit_out_valid, busy, done
    );

endinterface

// File: rtl/harness_word_serializer.sv
// Parallel-to-serial transmitter for the single-pin FPGA harness.
// Accepts a word on valid/ready and shifts it out one bit per clock, MSB
// first by default so a harness deserializer of equal width ends up holding
// the exact word.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : harness_word_serializer_if.slave (clear, word in, serial out)
//
// state  | meaning
// IDLE   | no word in flight, ready for a new word
// SHIFT  | a word bit is on bit_out; bit_cnt = bits still to follow
// GAP    | enforced idle line between words, gap_cnt cycles remaining
module harness_word_serializer
    import harness_word_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_CMD_WIDTH,
    parameter int IDLE_GAP   = 0,
    parameter bit LSB_FIRST  = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    harness_word_serializer_if.slave bus
);

    localparam int BIT_CNT_W = clog2(WORD_WIDTH) + 1;
    localparam int GAP_CNT_W = clog2(IDLE_GAP) + 1;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LOAD = BIT_CNT_W'(WORD_WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_CNT_LOAD =
        (IDLE_GAP > 0) ? GAP_CNT_W'(IDLE_GAP - 1) : '0;
    localparam bit BACK_TO_BACK = (IDLE_GAP == 0);

    state_t                state, state_n;
    logic [WORD_WIDTH-1:0] shift_reg, shift_n, shifted;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [GAP_CNT_W-1:0]  gap_cnt, gap_cnt_n;
    logic                  bit_out_r, bit_out_n;
    logic                  valid_r, valid_n;
    logic                  done_r, done_n;
    logic                  last_bit;
    logic                  ready;
    logic                  accept;

    always_comb begin
        last_bit = (state == ST_SHIFT) && (bit_cnt == '0);
        // Reload straight out of the last bit keeps the line gapless.
        ready    = ((state == ST_IDLE) || (last_bit && BACK_TO_BACK)) && !bus.clear;
        accept   = bus.word_in_valid && ready;
        shifted  = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift_reg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        bit_out_n = 1'b0;
        valid_n   = 1'b0;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    shift_n   = shifted;
                    bit_cnt_n = bit_cnt - 1'b1;
                    bit_out_n = LSB_FIRST ? shifted[0] : shifted[WORD_WIDTH-1];
                    valid_n   = 1'b1;
                    done_n    = (bit_cnt == BIT_CNT_W'(1));
                end else if (!BACK_TO_BACK) begin
                    state_n   = ST_GAP;
                    gap_cnt_n = GAP_CNT_LOAD;
                end else begin
                    state_n   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Accept is only possible from IDLE or the last SHIFT cycle, so it
        // overrides whatever exit the case statement chose.
        if (accept) begin
            state_n   = ST_SHIFT;
            shift_n   = bus.word_in;
            bit_cnt_n = BIT_CNT_LOAD;
            bit_out_n = LSB_FIRST ? bus.word_in[0] : bus.word_in[WORD_WIDTH-1];
            valid_n   = 1'b1;
            done_n    = (WORD_WIDTH == 1);
        end

        if (bus.clear) begin
            state_n   = ST_IDLE;
            shift_n   = '0;
            bit_cnt_n = '0;
            gap_cnt_n = '0;
            bit_out_n = 1'b0;
            valid_n   = 1'b0;
            done_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            bit_out_r <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            bit_out_r <= bit_out_n;
            valid_r   <= valid_n;
            done_r    <= done_n;
        end
    end

    assign bus.word_in_ready = ready;
    assign bus.bit_out       = bit_out_r;
    assign bus.bit_out_valid = valid_r;
    assign bus.done          = done_r;
    assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_harness_word_serializer.sv
// Five serializer variants share one clock and reset:
//   0: W=8 gap 0 MSB   1: W=8 gap 0 LSB   2: W=8 gap 3 MSB
//   3: W=286 gap 0 MSB (loopback)         4: W=1 gap 0
// The reference model tracks, per variant, the cycle of the latest accepted
// word; every output is derived from the distance to that cycle.
module tb_harness_word_serializer;

    typedef logic [285:0] word_t;

    localparam int N_DUT     = 5;
    localparam int BUF_DEPTH = 64;
    localparam int W_P   [N_DUT] = '{8, 8, 8, 286, 1};
    localparam int GAP_P [N_DUT] = '{0, 0, 3, 0, 0};
    localparam bit LSB_P [N_DUT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic  clk = 1'b0;
    logic  rst;
    logic  clr [N_DUT];
    logic  vin [N_DUT];
    word_t win [N_DUT];
    logic  rdy [N_DUT];
    logic  bo  [N_DUT];
    logic  bov [N_DUT];
    logic  bsy [N_DUT];
    logic  dn  [N_DUT];

    int    checks;
    int    failures;
    int    cyc;
    bit    act   [N_DUT];
    int    t_acc [N_DUT];
    word_t wacc  [N_DUT];
    word_t txbuf [N_DUT][BUF_DEPTH];
    int    wr_ptr [N_DUT];
    int    rd_ptr [N_DUT];
    bit    throttle;
    word_t deser;
    int    deser_cnt;
    word_t loop_word;

    int    m_d;
    logic  e_valid, e_bit, e_done, e_busy, e_ready;

    always #5 clk = ~clk;

    harness_word_serializer_if #(.WORD_WIDTH(8))   bus0 ();
    harness_word_serializer_if #(.WORD_WIDTH(8))   bus1 ();
    harness_word_serializer_if #(.WORD_WIDTH(8))   bus2 ();
    harness_word_serializer_if #(.WORD_WIDTH(286)) bus3 ();
    harness_word_serializer_if #(.WORD_WIDTH(1))   bus4 ();

    harness_word_serializer #(.WORD_WIDTH(8), .IDLE_GAP(0), .LSB_FIRST(1'b0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    harness_word_serializer #(.WORD_WIDTH(8), .IDLE_GAP(0), .LSB_FIRST(1'b1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    harness_word_serializer #(.WORD_WIDTH(8), .IDLE_GAP(3), .LSB_FIRST(1'b0))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    harness_word_serializer #(.WORD_WIDTH(286), .IDLE_GAP(0), .LSB_FIRST(1'b0))
        u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    harness_word_serializer #(.WORD_WIDTH(1), .IDLE_GAP(0), .LSB_FIRST(1'b0))
        u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus0.clear = clr[0];
    assign bus0.word_in = win[0][7:0];
    assign bus0.word_in_valid = vin[0];
    assign rdy[0] = bus0.word_in_ready;
    assign bo[0]  = bus0.bit_out;
    assign bov[0] = bus0.bit_out_valid;
    assign bsy[0] = bus0.busy;
    assign dn[0]  = bus0.done;

    assign bus1.clear = clr[1];
    assign bus1.word_in = win[1][7:0];
    assign bus1.word_in_valid = vin[1];
    assign rdy[1] = bus1.word_in_ready;
    assign bo[1]  = bus1.bit_out;
    assign bov[1] = bus1.bit_out_valid;
    assign bsy[1] = bus1.busy;
    assign dn[1]  = bus1.done;

    assign bus2.clear = clr[2];
    assign bus2.word_in = win[2][7:0];
    assign bus2.word_in_valid = vin[2];
    assign rdy[2] = bus2.word_in_ready;
    assign bo[2]  = bus2.bit_out;
    assign bov[2] = bus2.bit_out_valid;
    assign bsy[2] = bus2.busy;
    assign dn[2]  = bus2.done;

    assign bus3.clear = clr[3];
    assign bus3.word_in = win[3];
    assign bus3.word_in_valid = vin[3];
    assign rdy[3] = bus3.word_in_ready;
    assign bo[3]  = bus3.bit_out;
    assign bov[3] = bus3.bit_out_valid;
    assign bsy[3] = bus3.busy;
    assign dn[3]  = bus3.done;

    assign bus4.clear = clr[4];
    assign bus4.word_in = win[4][0:0];
    assign bus4.word_in_valid = vin[4];
    assign rdy[4] = bus4.word_in_ready;
    assign bo[4]  = bus4.bit_out;
    assign bov[4] = bus4.bit_out_valid;
    assign bsy[4] = bus4.busy;
    assign dn[4]  = bus4.done;

    task automatic check_value(input string tag, input word_t obs, input word_t exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rand_word();
        logic [287:0] r;
        for (int j = 0; j < 9; j++) begin
            r[j*32 +: 32] = $urandom();
        end
        return r[285:0];
    endfunction

    task automatic push(input int i, input word_t w);
        txbuf[i][wr_ptr[i]] = w;
        wr_ptr[i] = wr_ptr[i] + 1;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N_DUT; i++) begin
            if (rd_ptr[i] != wr_ptr[i]) return 1'b0;
            if (act[i] && (cyc - t_acc[i]) <= W_P[i] + GAP_P[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(posedge clk);
            #2;
            if (all_idle()) begin
                ok = 1'b1;
                break;
            end
        end
        check_value("drain_in_time", word_t'(ok), word_t'(1'b1));
    endtask

    task automatic wait_bit0(input int pos, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #2;
            if (act[0] && (cyc - t_acc[0]) == pos) begin
                ok = 1'b1;
                break;
            end
        end
        check_value(tag, word_t'(ok), word_t'(1'b1));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            if (rd_ptr[i] < wr_ptr[i] && (!throttle || $urandom_range(0, 3) != 0)) begin
                vin[i] = 1'b1;
                win[i] = txbuf[i][rd_ptr[i]];
            end else begin
                vin[i] = 1'b0;
                win[i] = rand_word();
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (rst) begin
                act[i]  = 1'b0;
                e_valid = 1'b0;
                e_bit   = 1'b0;
                e_done  = 1'b0;
                e_busy  = 1'b0;
                e_ready = !clr[i];
            end else begin
                m_d     = cyc - t_acc[i];
                e_valid = act[i] && m_d >= 1 && m_d <= W_P[i];
                e_done  = act[i] && m_d == W_P[i];
                e_busy  = act[i] && m_d >= 1 && m_d <= W_P[i] + GAP_P[i];
                e_ready = !clr[i] && (!act[i] ||
                          m_d >= W_P[i] + GAP_P[i] + ((GAP_P[i] > 0) ? 1 : 0));
                e_bit   = 1'b0;
                if (e_valid) begin
                    e_bit = LSB_P[i] ? wacc[i][m_d-1] : wacc[i][W_P[i]-m_d];
                end
            end
            check_value($sformatf("dut%0d_valid", i), word_t'(bov[i]), word_t'(e_valid));
            check_value($sformatf("dut%0d_bit", i),   word_t'(bo[i]),  word_t'(e_bit));
            check_value($sformatf("dut%0d_done", i),  word_t'(dn[i]),  word_t'(e_done));
            check_value($sformatf("dut%0d_busy", i),  word_t'(bsy[i]), word_t'(e_busy));
            check_value($sformatf("dut%0d_ready", i), word_t'(rdy[i]), word_t'(e_ready));
            if (!rst) begin
                if (clr[i]) begin
                    act[i] = 1'b0;
                end else if (vin[i] && e_ready) begin
                    act[i]    = 1'b1;
                    t_acc[i]  = cyc;
                    wacc[i]   = win[i];
                    rd_ptr[i] = rd_ptr[i] + 1;
                end
            end
        end
        if (!rst && bov[3]) begin
            deser     = {deser[284:0], bo[3]};
            deser_cnt = deser_cnt + 1;
        end
    end

    initial begin
        rst       = 1'b1;
        throttle  = 1'b0;
        deser     = '0;
        deser_cnt = 0;
        loop_word = {1'b1, 1'b0, 1'b1, 283'h1234_5678_9ABC};
        for (int i = 0; i < N_DUT; i++) clr[i] = 1'b0;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check_value($sformatf("dut%0d_ready_after_reset", i), word_t'(rdy[i]), word_t'(1'b1));
        end

        push(0, 286'hA5); push(0, 286'h3C);
        push(1, 286'h3C); push(1, 286'hA5);
        push(2, 286'hA5); push(2, 286'h3C);
        push(3, loop_word);
        push(4, 286'h1); push(4, 286'h0); push(4, 286'h1); push(4, 286'h1);
        wait_idle(1000);
        check_value("loopback_count", word_t'(deser_cnt), word_t'(286));
        check_value("loopback_word", deser, loop_word);

        // clear while the fourth bit of A5 is on the line
        push(0, 286'hA5);
        wait_bit0(4, "abort_reach_bit4");
        clr[0] = 1'b1;
        @(posedge clk);
        #2 clr[0] = 1'b0;
        push(0, 286'hFF);
        wait_idle(200);

        // asynchronous reset in the middle of a word
        push(0, 286'hA5);
        push(3, rand_word());
        wait_bit0(5, "rst_reach_bit5");
        rst = 1'b1;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check_value($sformatf("dut%0d_rst_valid", i), word_t'(bov[i]), word_t'(1'b0));
            check_value($sformatf("dut%0d_rst_bit", i),   word_t'(bo[i]),  word_t'(1'b0));
            check_value($sformatf("dut%0d_rst_done", i),  word_t'(dn[i]),  word_t'(1'b0));
            check_value($sformatf("dut%0d_rst_busy", i),  word_t'(bsy[i]), word_t'(1'b0));
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_value("ready_after_midword_rst", word_t'(rdy[0]), word_t'(1'b1));

        throttle = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            for (int k = 0; k < ((i == 3) ? 4 : 40); k++) push(i, rand_word());
        end
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N_DUT; i++) clr[i] = ($urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < N_DUT; i++) clr[i] = 1'b0;
        wait_idle(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
